// File: rtl/vending_ctrl.sv
// vending_ctrl: accumulates three coin denominations against PRICE, holds vend until ack, then pays change.
// Build macro VEND_TIMEOUT_EN adds an inactivity auto-refund while collecting (TIMEOUT_CYC cycles).
module vending_ctrl #(
    parameter int CREDIT_W    = 6,
    parameter int PRICE       = 15,
    parameter int COIN_A      = 1,
    parameter int COIN_B      = 5,
    parameter int COIN_C      = 10,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin_in,
    input  logic                cancel,
    input  logic                vend_ack,
    output logic                vend,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_t;

    localparam logic [CREDIT_W:0]   MAX_SUM = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   VAL_A   = (CREDIT_W + 1)'(COIN_A);
    localparam logic [CREDIT_W:0]   VAL_B   = (CREDIT_W + 1)'(COIN_B);
    localparam logic [CREDIT_W:0]   VAL_C   = (CREDIT_W + 1)'(COIN_C);

    // Configurations that cannot work are stopped at elaboration.
    if (PRICE < 1 || PRICE > (1 << CREDIT_W) - 1) begin : g_bad_price
        $error("vending_ctrl: PRICE outside 1 .. 2^CREDIT_W-1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("vending_ctrl: TIMEOUT_CYC must be at least 1");
    end

    function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W:0] val;
        case (code)
            2'b01:   val = VAL_A;
            2'b10:   val = VAL_B;
            2'b11:   val = VAL_C;
            default: val = {(CREDIT_W + 1){1'b0}};
        endcase
        return val;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CREDIT_W-1:0] credit_nxt_s;
    logic                reject_nxt_s;
    logic [CREDIT_W:0]   sum_s;
    logic                coin_s;
    logic                coin_ok_s;
    logic [CREDIT_W-1:0] vend_rem_s;
    logic                tmo_hit_s;

    assign coin_s     = (coin_in != 2'b00);
    assign sum_s      = {1'b0, credit} + coin_value(coin_in);
    assign coin_ok_s  = coin_s && (sum_s <= MAX_SUM);
    assign vend_rem_s = credit - PRICE_C;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_r;

    assign tmo_hit_s = (state_r == S_COLLECT) && (tmo_r == TMO_LAST) && !coin_ok_s;

    // Inactivity counter: advances only while staying in COLLECT without an accepted coin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if ((state_r == S_COLLECT) && (state_nxt_s == S_COLLECT) && !coin_ok_s) begin
            tmo_r <= tmo_r + {{(TMO_W - 1){1'b0}}, 1'b1};
        end else begin
            tmo_r <= {TMO_W{1'b0}};
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state, next-credit and coin-refusal decision for the controller.
    always_comb begin
        state_nxt_s  = state_r;
        credit_nxt_s = credit;
        reject_nxt_s = 1'b0;
        case (state_r)
            S_IDLE, S_COLLECT: begin
                if ((state_r == S_COLLECT) && (cancel || tmo_hit_s)) begin
                    // Refund wins over a coin landing in the same cycle; that coin goes back.
                    reject_nxt_s = coin_s;
                    state_nxt_s  = (credit == {CREDIT_W{1'b0}}) ? S_IDLE : S_CHANGE;
                end else if (coin_ok_s) begin
                    credit_nxt_s = sum_s[CREDIT_W-1:0];
                    state_nxt_s  = (sum_s >= PRICE_W) ? S_VEND : S_COLLECT;
                end else begin
                    reject_nxt_s = coin_s;
                end
            end
            S_VEND: begin
                reject_nxt_s = coin_s;
                if (vend_ack) begin
                    credit_nxt_s = vend_rem_s;
                    state_nxt_s  = (vend_rem_s == {CREDIT_W{1'b0}}) ? S_IDLE : S_CHANGE;
                end else begin
                    state_nxt_s = S_VEND;
                end
            end
            S_CHANGE: begin
                reject_nxt_s = coin_s;
                if (credit > {{(CREDIT_W - 1){1'b0}}, 1'b1}) begin
                    credit_nxt_s = credit - {{(CREDIT_W - 1){1'b0}}, 1'b1};
                    state_nxt_s  = S_CHANGE;
                end else begin
                    credit_nxt_s = {CREDIT_W{1'b0}};
                    state_nxt_s  = S_IDLE;
                end
            end
            default: begin
                credit_nxt_s = {CREDIT_W{1'b0}};
                state_nxt_s  = S_IDLE;
            end
        endcase
    end

    // Controller state register with all outputs registered from the next-state decision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            credit       <= {CREDIT_W{1'b0}};
            vend         <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            credit       <= credit_nxt_s;
            vend         <= (state_nxt_s == S_VEND);
            change_pulse <= (state_nxt_s == S_CHANGE);
            coin_reject  <= reject_nxt_s;
            busy         <= (state_nxt_s == S_VEND) || (state_nxt_s == S_CHANGE);
        end
    end

endmodule
